// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, ctrl bit map,
// and frame geometry.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Bit positions inside the ctrl input.
    localparam int CTRL_EN  = 0;
    localparam int CTRL_ACK = 1;

    // 8N1 frame: one start bit, eight data bits, one stop bit.
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Resets to the
// idle-high level so a reset never looks like a start-bit edge.
module uart_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge value of its neighbours, exactly like the hardware.
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a single-byte holding register
// and sticky status flags (valid, framing error, overrun) cleared by rx_ack.
module uart_rx
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 16,
    localparam int HALF         = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pin,
    input  logic [7:0] ctrl,
    output logic [7:0] data,
    output logic       state_rx_en,
    output logic       state_rx_busy,
    output logic       state_rx_valid,
    output logic       state_rx_ferr,
    output logic       state_rx_overrun
);

    // The counter must hold CLKS_PER_BIT itself, since a bit ends when
    // cnt reaches CLKS_PER_BIT and restarts at 1.
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    logic             s_pin;
    logic             s_pin_prev_q;
    logic             rx_en;
    logic             rx_ack;
    logic             ctrl_unused;

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             en_q;
    logic             valid_q;
    logic             ferr_q;
    logic             overrun_q;

    uart_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (pin),
        .q_o   (s_pin)
    );

    assign rx_en       = ctrl[CTRL_EN];
    assign rx_ack      = ctrl[CTRL_ACK];
    assign ctrl_unused = ^ctrl[7:2];

    // Receiver FSM, bit timing, shift register and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_pin_prev_q <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            en_q         <= 1'b0;
            valid_q      <= 1'b0;
            ferr_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            s_pin_prev_q <= s_pin;
            en_q         <= rx_en;

            // Acknowledge clears all flags; a byte completing in the same
            // cycle is assigned later in this block and therefore wins.
            if (rx_ack) begin
                valid_q   <= 1'b0;
                ferr_q    <= 1'b0;
                overrun_q <= 1'b0;
            end

            if (state_q != IDLE && !rx_en) begin
                // Disabling mid-frame drops the partial byte silently.
                state_q <= IDLE;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // Edge-triggered start: a line stuck low never restarts.
                        if (rx_en && s_pin_prev_q && !s_pin) begin
                            state_q <= START;
                            cnt_q   <= CNT_ONE;
                        end
                    end

                    START: begin
                        if (cnt_q == CNT_HALF) begin
                            if (s_pin) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= DATA;
                                cnt_q   <= CNT_ONE;
                                idx_q   <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end

                    DATA: begin
                        if (cnt_q == CNT_BIT) begin
                            shift_q <= {s_pin, shift_q[7:1]};
                            cnt_q   <= CNT_ONE;
                            if (idx_q == LAST_IDX) begin
                                state_q <= STOP;
                                idx_q   <= '0;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end

                    STOP: begin
                        if (cnt_q == CNT_BIT) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            data_q  <= shift_q;
                            if (s_pin) begin
                                valid_q   <= 1'b1;
                                overrun_q <= valid_q && !rx_ack;
                            end else begin
                                ferr_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign data             = data_q;
    assign state_rx_en      = en_q;
    assign state_rx_busy    = (state_q != IDLE);
    assign state_rx_valid   = valid_q;
    assign state_rx_ferr    = ferr_q;
    assign state_rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 4 clocks per bit. Inputs change 1 ns
// after a rising edge; outputs are sampled on the falling edge.
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       pin;
    logic [7:0] ctrl;
    logic [7:0] data;
    logic       st_en;
    logic       st_busy;
    logic       st_valid;
    logic       st_ferr;
    logic       st_ovr;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk              (clk),
        .reset            (reset),
        .pin              (pin),
        .ctrl             (ctrl),
        .data             (data),
        .state_rx_en      (st_en),
        .state_rx_busy    (st_busy),
        .state_rx_valid   (st_valid),
        .state_rx_ferr    (st_ferr),
        .state_rx_overrun (st_ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       valid;
        logic       ferr;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the first nbits of an LSB-first 8N1 frame.
    task automatic send_bits(input logic [7:0] b, input logic stop, input int nbits);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        tick();
        for (int i = 0; i < nbits; i++) begin
            pin = bits[i];
            repeat (CPB) tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic release_line,
                              input logic exp_valid);
        exp_t e;
        e.d = b;
        e.valid = exp_valid;
        e.ferr = ~stop;
        sb.push_back(e);
        send_bits(b, stop, 10);
        if (release_line) pin = 1'b1;
    endtask

    // Bounded wait for the receiver to go idle again.
    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!st_busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_idle_timeout"}, {31'd0, done}, 32'd1);
    endtask

    // Pop the scoreboard and compare the completed byte.
    task automatic check_frame(input string name, input logic exp_ovr);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, "_data"},  {24'd0, data},     {24'd0, e.d});
            check({name, "_valid"}, {31'd0, st_valid}, {31'd0, e.valid});
            check({name, "_ferr"},  {31'd0, st_ferr},  {31'd0, e.ferr});
            check({name, "_ovr"},   {31'd0, st_ovr},   {31'd0, exp_ovr});
        end
    endtask

    task automatic ack_pulse();
        ctrl = 8'h03;
        tick();
        ctrl = 8'h01;
    endtask

    vec_t vecs[5];
    int   busy_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h81, 1'b1, 8'h81, 1'b1, 1'b0};
        vecs[4] = '{8'hC3, 1'b0, 8'hC3, 1'b0, 1'b1};

        // Reset state.
        reset = 1'b1;
        pin   = 1'b1;
        ctrl  = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_data",  {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, st_valid}, 32'd0);
        check("rst_ferr",  {31'd0, st_ferr}, 32'd0);
        check("rst_ovr",   {31'd0, st_ovr}, 32'd0);
        check("rst_busy",  {31'd0, st_busy}, 32'd0);
        check("rst_en",    {31'd0, st_en}, 32'd0);

        ctrl = 8'h01;
        tick();
        @(negedge clk);
        check("en_copy", {31'd0, st_en}, 32'd1);
        repeat (2) tick();

        // Exact completion latency for 0xA5.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("lat_valid_early", {31'd0, st_valid}, 32'd0);
        check("lat_busy_early",  {31'd0, st_busy}, 32'd1);
        tick();
        @(negedge clk);
        check("lat_busy_done", {31'd0, st_busy}, 32'd0);
        check_frame("lat_a5", 1'b0);
        tick();
        ack_pulse();
        @(negedge clk);
        check("lat_ack_valid", {31'd0, st_valid}, 32'd0);

        // One-cycle glitch: two busy cycles, no flags.
        tick();
        pin = 1'b0;
        tick();
        pin = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (st_busy) busy_cnt++;
        end
        check("glitch_busy_cycles", busy_cnt, 32'd2);
        check("glitch_valid", {31'd0, st_valid}, 32'd0);
        check("glitch_ferr",  {31'd0, st_ferr}, 32'd0);

        // Table-driven frames, each acknowledged afterwards.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].b, vecs[i].stop, 1'b1, vecs[i].exp_valid);
            wait_idle("tbl");
            check_frame($sformatf("tbl%0d", i), 1'b0);
            check($sformatf("tbl%0d_vec_data", i), {24'd0, data}, {24'd0, vecs[i].exp_data});
            tick();
            ack_pulse();
            @(negedge clk);
            check($sformatf("tbl%0d_ack_valid", i), {31'd0, st_valid}, 32'd0);
            check($sformatf("tbl%0d_ack_ferr", i),  {31'd0, st_ferr}, 32'd0);
        end

        // Framing error with the line then held low: no retrigger.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_idle("ferr");
        check_frame("ferr_3c", 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (st_busy) busy_cnt++;
        end
        check("hold_low_busy", busy_cnt, 32'd0);
        tick();
        pin = 1'b1;
        repeat (4) tick();
        ack_pulse();

        // Overrun: two frames without acknowledge.
        send_frame(8'h11, 1'b1, 1'b1, 1'b1);
        wait_idle("ovr1");
        check_frame("ovr_11", 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b1);
        wait_idle("ovr2");
        check_frame("ovr_22", 1'b1);
        tick();
        ack_pulse();
        @(negedge clk);
        check("ovr_ack_clear", {29'd0, st_valid, st_ferr, st_ovr}, 32'd0);

        // Acknowledge in the completion cycle: completion wins.
        send_frame(8'h11, 1'b1, 1'b1, 1'b1);
        wait_idle("race1");
        check_frame("race_11", 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b1);
        ctrl = 8'h03;
        tick();
        ctrl = 8'h01;
        @(negedge clk);
        check_frame("race_22", 1'b0);
        tick();
        ack_pulse();

        // Reset in the middle of a frame, then a clean frame.
        send_bits(8'hFF, 1'b1, 5);
        @(negedge clk);
        check("mid_busy", {31'd0, st_busy}, 32'd1);
        tick();
        reset = 1'b1;
        pin   = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, st_busy}, 32'd0);
        check("midrst_data", {24'd0, data}, 32'h00);
        check("midrst_flags", {29'd0, st_valid, st_ferr, st_ovr}, 32'd0);
        check("midrst_en", {31'd0, st_en}, 32'd0);
        repeat (4) tick();
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        wait_idle("after_rst");
        check_frame("after_rst_5a", 1'b0);
        tick();
        ack_pulse();

        // Dropping rx_en mid-frame aborts without touching data.
        repeat (2) tick();
        send_bits(8'h0F, 1'b1, 4);
        @(negedge clk);
        check("abort_busy_before", {31'd0, st_busy}, 32'd1);
        tick();
        ctrl = 8'h00;
        tick();
        @(negedge clk);
        check("abort_busy", {31'd0, st_busy}, 32'd0);
        check("abort_data", {24'd0, data}, 32'h5A);
        check("abort_flags", {29'd0, st_valid, st_ferr, st_ovr}, 32'd0);
        pin = 1'b1;
        repeat (4) tick();

        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
